// File: rtl/calendar_clock_counter_if.sv
// Bus bundle for calendar_clock_counter: enable, load request/fields and the
// time/date outputs with their strobes. The alarm signals exist only when
// CAL_ALARM_EN is defined.
interface calendar_clock_counter_if #(
  parameter int YEAR_W = 12
) ();
  logic              en;
  logic              load;
  logic [5:0]        ld_sec;
  logic [5:0]        ld_min;
  logic [4:0]        ld_hrs;
  logic [4:0]        ld_day;
  logic [3:0]        ld_month;
  logic [YEAR_W-1:0] ld_year;
  logic [5:0]        sec;
  logic [5:0]        min;
  logic [4:0]        hrs;
  logic [4:0]        day;
  logic [3:0]        month;
  logic [YEAR_W-1:0] year;
  logic              leap;
  logic              new_day;
  logic              new_year;
  logic              load_err;
`ifdef CAL_ALARM_EN
  logic              alarm_set;
  logic [4:0]        al_hrs;
  logic [5:0]        al_min;
  logic              alarm_clr;
  logic              alarm;
`endif

  modport master (
`ifdef CAL_ALARM_EN
    output alarm_set, al_hrs, al_min, alarm_clr,
    input  alarm,
`endif
    output en, load, ld_sec, ld_min, ld_hrs, ld_day, ld_month, ld_year,
    input  sec, min, hrs, day, month, year, leap, new_day, new_year, load_err
  );

  modport slave (
`ifdef CAL_ALARM_EN
    input  alarm_set, al_hrs, al_min, alarm_clr,
    output alarm,
`endif
    input  en, load, ld_sec, ld_min, ld_hrs, ld_day, ld_month, ld_year,
    output sec, min, hrs, day, month, year, leap, new_day, new_year, load_err
  );
endinterface

// File: rtl/calendar_clock_counter.sv
// calendar_clock_counter: time-of-day + Gregorian calendar counter with an
// internal seconds prescaler and validated parallel load.
// Optional feature macro: CAL_ALARM_EN (sticky hh:mm alarm).
module calendar_clock_counter #(
  parameter int TICK_DIV   = 1,
  parameter int YEAR_W     = 12,
  parameter int START_YEAR = 2000
) (
  input logic                     clk,
  input logic                     rst,
  calendar_clock_counter_if.slave bus
);
  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]     presc_q, presc_n;
  logic [5:0]        sec_q, sec_n, min_q, min_n;
  logic [4:0]        hrs_q, hrs_n, day_q, day_n;
  logic [3:0]        mon_q, mon_n;
  logic [YEAR_W-1:0] year_q, year_n;
  logic              nd_q, nd_n, ny_q, ny_n, err_q, err_n;
  logic              sec_tick, ld_ok;

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    logic [31:0] v;
    v = 32'(y);
    return ((v % 32'd4) == 32'd0) &&
           (((v % 32'd100) != 32'd0) || ((v % 32'd400) == 32'd0));
  endfunction

  function automatic logic [4:0] day_max(input logic [3:0] m, input logic lp);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return lp ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  assign sec_tick = bus.en && (presc_q == PMAX);

  assign ld_ok = (bus.ld_sec <= 6'd59) && (bus.ld_min <= 6'd59) &&
                 (bus.ld_hrs <= 5'd23) &&
                 (bus.ld_month >= 4'd1) && (bus.ld_month <= 4'd12) &&
                 (bus.ld_day >= 5'd1) &&
                 (bus.ld_day <= day_max(bus.ld_month, is_leap(bus.ld_year)));

  // Next-state: valid load wins over the tick; a rejected load leaves the
  // prescaler and time running as if no load had been requested.
  always_comb begin
    presc_n = presc_q;
    sec_n   = sec_q;
    min_n   = min_q;
    hrs_n   = hrs_q;
    day_n   = day_q;
    mon_n   = mon_q;
    year_n  = year_q;
    nd_n    = 1'b0;
    ny_n    = 1'b0;
    err_n   = 1'b0;
    if (bus.load && ld_ok) begin
      presc_n = '0;
      sec_n   = bus.ld_sec;
      min_n   = bus.ld_min;
      hrs_n   = bus.ld_hrs;
      day_n   = bus.ld_day;
      mon_n   = bus.ld_month;
      year_n  = bus.ld_year;
    end else begin
      err_n = bus.load;
      if (bus.en) presc_n = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
      if (sec_tick) begin
        if (sec_q == 6'd59) begin
          sec_n = '0;
          if (min_q == 6'd59) begin
            min_n = '0;
            if (hrs_q == 5'd23) begin
              hrs_n = '0;
              nd_n  = 1'b1;
              if (day_q == day_max(mon_q, is_leap(year_q))) begin
                day_n = 5'd1;
                if (mon_q == 4'd12) begin
                  mon_n  = 4'd1;
                  year_n = year_q + YEAR_W'(1);
                  ny_n   = 1'b1;
                end else begin
                  mon_n = mon_q + 4'd1;
                end
              end else begin
                day_n = day_q + 5'd1;
              end
            end else begin
              hrs_n = hrs_q + 5'd1;
            end
          end else begin
            min_n = min_q + 6'd1;
          end
        end else begin
          sec_n = sec_q + 6'd1;
        end
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hrs_q   <= '0;
      day_q   <= 5'd1;
      mon_q   <= 4'd1;
      year_q  <= YEAR_W'(START_YEAR);
      nd_q    <= 1'b0;
      ny_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_n;
      sec_q   <= sec_n;
      min_q   <= min_n;
      hrs_q   <= hrs_n;
      day_q   <= day_n;
      mon_q   <= mon_n;
      year_q  <= year_n;
      nd_q    <= nd_n;
      ny_q    <= ny_n;
      err_q   <= err_n;
    end
  end

  assign bus.sec      = sec_q;
  assign bus.min      = min_q;
  assign bus.hrs      = hrs_q;
  assign bus.day      = day_q;
  assign bus.month    = mon_q;
  assign bus.year     = year_q;
  assign bus.leap     = is_leap(year_q);
  assign bus.new_day  = nd_q;
  assign bus.new_year = ny_q;
  assign bus.load_err = err_q;

`ifdef CAL_ALARM_EN
  logic [4:0] al_h_q;
  logic [5:0] al_m_q;
  logic       alarm_q, time_upd, al_match;

  assign time_upd = (bus.load && ld_ok) || sec_tick;
  assign al_match = time_upd && (hrs_n == al_h_q) && (min_n == al_m_q) &&
                    (sec_n == 6'd0);

  // Alarm time latch and sticky flag; a match wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      al_h_q  <= '0;
      al_m_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      if (bus.alarm_set) begin
        al_h_q <= bus.al_hrs;
        al_m_q <= bus.al_min;
      end
      if (al_match)           alarm_q <= 1'b1;
      else if (bus.alarm_clr) alarm_q <= 1'b0;
    end
  end

  assign bus.alarm = alarm_q;
`endif
endmodule
